// File: rtl/codec_cfg_pkg.sv
// Shared constants for the codec configuration sequencer: WM8731 register map,
// the default bring-up table and the sequencer state encoding.
// No logic; imported by the sequencer files.
package codec_cfg_pkg;

    // WM8731 control register addresses (7-bit)
    localparam logic [6:0] LIN_VOL = 7'h00;
    localparam logic [6:0] HP_VOL  = 7'h02;
    localparam logic [6:0] APATH   = 7'h04;
    localparam logic [6:0] DPATH   = 7'h05;
    localparam logic [6:0] PWR     = 7'h06;
    localparam logic [6:0] IFACE   = 7'h07;
    localparam logic [6:0] SAMPLE  = 7'h08;
    localparam logic [6:0] ACTIVE  = 7'h09;
    localparam logic [6:0] RESET   = 7'h0F;

    // 11-word bring-up, entry 0 in the LSBs: reset, power sequencing, paths,
    // interface format, sample rate, activate, final power-up.
    localparam logic [175:0] CODEC_BOOT_TABLE = {
        16'h0C00, 16'h1201, 16'h1000, 16'h0E5B, 16'h0A01, 16'h0810,
        16'h057C, 16'h011F, 16'h0C10, 16'h0C00, 16'h1E00
    };

    // Sequencer states; XFER covers CS setup, shifting and CS hold, which are
    // timed inside spi_word_tx.
    typedef enum logic [2:0] {
        ST_POR_WAIT = 3'd0,
        ST_LOAD     = 3'd1,
        ST_XFER     = 3'd2,
        ST_GAP      = 3'd3,
        ST_IDLE     = 3'd4
    } seq_state_e;

endpackage

// File: rtl/codec_cfg_seq_if.sv
// Runtime register-write request port (valid/ready) into the codec sequencer.
// Latency: none, pure wiring bundle.
// Backpressure: slave holds upd_ready low until it can take the write.
interface codec_cfg_seq_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 9
);
    logic              upd_valid;
    logic              upd_ready;
    logic [ADDR_W-1:0] upd_addr;
    logic [DATA_W-1:0] upd_data;

    modport master (output upd_valid, output upd_addr, output upd_data, input upd_ready);
    modport slave  (input upd_valid, input upd_addr, input upd_data, output upd_ready);
endinterface

// File: rtl/spi_word_tx.sv
// Serialises one word MSB first onto CS/SCK/MOSI (CS setup, shift, CS hold).
// Latency: CS falls 1 cycle after load; CS rises (2*WORD_W+2)*CLK_DIV cycles later.
// Backpressure: load is only honoured while idle; the caller must wait for done_pulse.
module spi_word_tx #(
    parameter int WORD_W  = 16,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WORD_W-1:0] word,
    output logic              cs,
    output logic              sck,
    output logic              mosi,
    output logic              done_pulse
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_SETUP = 2'd1;
    localparam logic [1:0] TX_SHIFT = 2'd2;
    localparam logic [1:0] TX_HOLD  = 2'd3;

    logic [1:0]        tx_state;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [WORD_W-1:0] shreg;
    logic              phase_end;

    assign phase_end  = (div_cnt == DIV_W'(CLK_DIV - 1));
    // MOSI comes straight off the shift-register MSB flop, so it only moves
    // when the register shifts (on SCK falling) or is loaded/cleared.
    assign mosi       = shreg[WORD_W-1];
    // Last cycle of CS hold: CS rises on the coming edge.
    assign done_pulse = (tx_state == TX_HOLD) && phase_end;

    // Phase timing: each phase lasts CLK_DIV cycles; SCK toggles at phase ends in SHIFT.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            cs       <= 1'b1;
            sck      <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (load) begin
                        shreg    <= word;
                        cs       <= 1'b0;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        tx_state <= TX_SETUP;
                    end
                end
                TX_SETUP: begin
                    if (phase_end) begin
                        div_cnt  <= '0;
                        tx_state <= TX_SHIFT;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                TX_SHIFT: begin
                    if (phase_end) begin
                        div_cnt <= '0;
                        if (!sck) begin
                            sck <= 1'b1;
                        end else begin
                            sck <= 1'b0;
                            if (bit_cnt == BIT_W'(WORD_W - 1)) begin
                                tx_state <= TX_HOLD;
                            end else begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                                shreg   <= {shreg[WORD_W-2:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    if (phase_end) begin
                        cs       <= 1'b1;
                        shreg    <= '0;
                        div_cnt  <= '0;
                        tx_state <= TX_IDLE;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/codec_cfg_seq.sv
// Codec configurator: power-on delay, boot-table playback, then runtime single writes.
// Latency: first CS fall POR_CYCLES+1 cycles after reset; word period (2*WORD_W+2)*CLK_DIV+GAP_CYCLES+1.
// Backpressure: upd_ready only in IDLE with reconfig low; reconfig outside IDLE is dropped.
module codec_cfg_seq
    import codec_cfg_pkg::*;
#(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 9,
    parameter int NUM_REGS   = 11,
    parameter logic [NUM_REGS*(ADDR_W+DATA_W)-1:0] INIT_TABLE = CODEC_BOOT_TABLE,
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 16,
    parameter int POR_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       reconfig,
    codec_cfg_seq_if.slave upd,
    output logic       spi_cs,
    output logic       spi_sck,
    output logic       spi_mosi,
    output logic       done,
    output logic       busy,
    output logic [5:0] word_idx
);
    localparam int WORD_W = ADDR_W + DATA_W;
    localparam int POR_W  = $clog2(POR_CYCLES + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

    seq_state_e        state;
    logic [POR_W-1:0]  por_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              src_upd;
    logic [WORD_W-1:0] upd_word;
    logic [WORD_W-1:0] tx_word;
    logic              tx_load;
    logic              tx_done;

    assign busy          = (state != ST_IDLE);
    assign upd.upd_ready = (state == ST_IDLE) && !reconfig;
    assign tx_load       = (state == ST_LOAD);

    // Pick the word to send: the latched runtime write or the current table entry.
    always_comb begin
        tx_word = INIT_TABLE[int'(word_idx)*WORD_W +: WORD_W];
        if (src_upd) begin
            tx_word = upd_word;
        end
    end

    // Sequencer: POR delay, inter-word gap, table stepping and IDLE arbitration.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_POR_WAIT;
            por_cnt  <= '0;
            gap_cnt  <= '0;
            word_idx <= '0;
            done     <= 1'b0;
            src_upd  <= 1'b0;
            upd_word <= '0;
        end else begin
            case (state)
                ST_POR_WAIT: begin
                    if (por_cnt == POR_W'(POR_CYCLES - 1)) begin
                        src_upd <= 1'b0;
                        state   <= ST_LOAD;
                    end else begin
                        por_cnt <= por_cnt + POR_W'(1);
                    end
                end
                ST_LOAD: begin
                    state <= ST_XFER;
                end
                ST_XFER: begin
                    if (tx_done) begin
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        if (src_upd) begin
                            state <= ST_IDLE;
                        end else if (word_idx != 6'(NUM_REGS - 1)) begin
                            word_idx <= word_idx + 6'd1;
                            state    <= ST_LOAD;
                        end else begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                ST_IDLE: begin
                    // Replay wins over a simultaneous write; that write is not taken.
                    if (reconfig) begin
                        done     <= 1'b0;
                        word_idx <= '0;
                        src_upd  <= 1'b0;
                        state    <= ST_LOAD;
                    end else if (upd.upd_valid) begin
                        upd_word <= {upd.upd_addr, upd.upd_data};
                        src_upd  <= 1'b1;
                        state    <= ST_LOAD;
                    end
                end
                default: begin
                    state <= ST_POR_WAIT;
                end
            endcase
        end
    end

    spi_word_tx #(
        .WORD_W  (WORD_W),
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk        (clk),
        .reset      (reset),
        .load       (tx_load),
        .word       (tx_word),
        .cs         (spi_cs),
        .sck        (spi_sck),
        .mosi       (spi_mosi),
        .done_pulse (tx_done)
    );
endmodule

// File: tb/tb_codec_cfg_seq.sv
// Scoreboarded bench: expected SPI words are queued as stimulus is issued and an
// SPI-slave monitor decodes every CS-low window of three DUT instances
// (defaults, CLK_DIV=1/one word, 8+8-bit words) and compares against the queue.
module tb_codec_cfg_seq;

    typedef struct {
        int          id;
        logic [15:0] word;
        int          low;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, rst1, rst2, reconfig;
    logic chk_first;
    int   rel_cyc = 0;

    // cycles since the last edge that saw the main reset high
    always @(posedge clk) rel_cyc <= reset ? 0 : rel_cyc + 1;

    localparam logic [15:0] BOOT [11] = '{16'h1E00, 16'h0C00, 16'h0C10, 16'h011F, 16'h057C,
                                         16'h0810, 16'h0A01, 16'h0E5B, 16'h1000, 16'h1201, 16'h0C00};

    logic       cs0, sck0, mosi0, done0, busy0;
    logic       cs1, sck1, mosi1, done1, busy1;
    logic       cs2, sck2, mosi2, done2, busy2;
    logic [5:0] widx0, widx1, widx2;

    codec_cfg_seq_if                           if0 ();
    codec_cfg_seq_if                           if1 ();
    codec_cfg_seq_if #(.ADDR_W(8), .DATA_W(8)) if2 ();

    codec_cfg_seq dut0 (
        .clk(clk), .reset(reset), .reconfig(reconfig), .upd(if0.slave),
        .spi_cs(cs0), .spi_sck(sck0), .spi_mosi(mosi0), .done(done0), .busy(busy0), .word_idx(widx0)
    );

    codec_cfg_seq #(
        .NUM_REGS(1), .INIT_TABLE(16'h1201), .CLK_DIV(1), .GAP_CYCLES(1), .POR_CYCLES(4)
    ) dut1 (
        .clk(clk), .reset(rst1), .reconfig(1'b0), .upd(if1.slave),
        .spi_cs(cs1), .spi_sck(sck1), .spi_mosi(mosi1), .done(done1), .busy(busy1), .word_idx(widx1)
    );

    codec_cfg_seq #(
        .ADDR_W(8), .DATA_W(8), .NUM_REGS(2), .INIT_TABLE(32'hA55A_81C3),
        .CLK_DIV(2), .GAP_CYCLES(3), .POR_CYCLES(5)
    ) dut2 (
        .clk(clk), .reset(rst2), .reconfig(1'b0), .upd(if2.slave),
        .spi_cs(cs2), .spi_sck(sck2), .spi_mosi(mosi2), .done(done2), .busy(busy2), .word_idx(widx2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int id, input logic [15:0] w, input int low);
        exp_t e;
        e.id   = id;
        e.word = w;
        e.low  = low;
        sbq.push_back(e);
    endtask

    // SPI-slave monitor state, one slot per DUT
    logic        pcs  [3];
    logic        psck [3];
    int          bits [3];
    int          lowcnt [3];
    logic [15:0] sh   [3];
    int          nwords [3] = '{default: 0};
    int          aborted [3] = '{default: 0};

    initial begin
        logic cs_v [3];
        logic sck_v [3];
        logic mosi_v [3];
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            pcs[d] = 1'b1; psck[d] = 1'b0; bits[d] = 0; lowcnt[d] = 0; sh[d] = '0;
        end
        forever begin
            @(negedge clk);
            cs_v   = '{cs0, cs1, cs2};
            sck_v  = '{sck0, sck1, sck2};
            mosi_v = '{mosi0, mosi1, mosi2};
            for (int d = 0; d < 3; d++) begin
                if (cs_v[d] === 1'b0) begin
                    if (pcs[d] === 1'b1) begin
                        bits[d] = 0; lowcnt[d] = 0; sh[d] = '0;
                        if (d == 0 && chk_first) begin
                            chk("first_cs_fall_cycle", rel_cyc, 33);
                            chk_first = 1'b0;
                        end
                    end
                    lowcnt[d]++;
                    if (sck_v[d] === 1'b1 && psck[d] === 1'b0) begin
                        sh[d] = {sh[d][14:0], mosi_v[d]};
                        bits[d]++;
                    end
                end else if (cs_v[d] === 1'b1 && pcs[d] === 1'b0) begin
                    // codec latches only a complete word on the CS rising edge
                    if (bits[d] == 16) begin
                        nwords[d]++;
                        if (sbq.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_word dut%0d: got 0x%04h, required none", d, sh[d]);
                        end else begin
                            e = sbq.pop_front();
                            chk("word_dut_id", d, e.id);
                            chk("word_value", sh[d], e.word);
                            chk("cs_low_cycles", lowcnt[d], e.low);
                        end
                    end else begin
                        aborted[d]++;
                    end
                end
                pcs[d]  = cs_v[d];
                psck[d] = sck_v[d];
            end
        end
    end

    initial begin
        int n0, dcnt, ab0;
        reset = 1'b1; rst1 = 1'b1; rst2 = 1'b1; reconfig = 1'b0; chk_first = 1'b0;
        if0.upd_valid = 1'b0; if0.upd_addr = '0; if0.upd_data = '0;
        if1.upd_valid = 1'b0; if1.upd_addr = '0; if1.upd_data = '0;
        if2.upd_valid = 1'b0; if2.upd_addr = '0; if2.upd_data = '0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_cs", cs0, 1); chk("rst_sck", sck0, 0); chk("rst_mosi", mosi0, 0);
        chk("rst_done", done0, 0); chk("rst_busy", busy0, 1);
        chk("rst_upd_ready", if0.upd_ready, 0); chk("rst_word_idx", widx0, 0);

        // boot: 32 POR + 11 * (1 + 136 + 16) = 1715
        for (int i = 0; i < 11; i++) push(0, BOOT[i], 136);
        chk_first = 1'b1;
        reset = 1'b0;
        for (int i = 0; i < 4000 && !done0; i++) @(negedge clk);
        chk("boot_done", done0, 1); chk("boot_done_cycle", rel_cyc, 1715);
        chk("boot_busy", busy0, 0); chk("boot_word_idx", widx0, 10);
        chk("boot_queue_empty", sbq.size(), 0); chk("boot_nwords", nwords[0], 11);

        // runtime write in IDLE: {0x02,0x160} = 0x0560
        n0 = nwords[0];
        @(negedge clk);
        if0.upd_valid = 1'b1; if0.upd_addr = 7'h02; if0.upd_data = 9'h160;
        #1;
        chk("upd_ready_idle", if0.upd_ready, 1);
        push(0, 16'h0560, 136);
        @(negedge clk);
        if0.upd_valid = 1'b0; if0.upd_addr = 7'h7F; if0.upd_data = 9'h1FF;
        chk("upd_ready_drop", if0.upd_ready, 0); chk("upd_busy", busy0, 1);
        dcnt = 0;
        for (int i = 0; i < 400 && busy0; i++) begin
            if (!done0) dcnt++;
            @(negedge clk);
        end
        chk("upd_idle", busy0, 0); chk("upd_done_low_cycles", dcnt, 0);
        chk("upd_done", done0, 1); chk("upd_word_idx", widx0, 10);
        chk("upd_nwords", nwords[0] - n0, 1); chk("upd_queue_empty", sbq.size(), 0);

        // reconfig together with upd_valid: replay wins, write dropped
        n0 = nwords[0];
        @(negedge clk);
        reconfig = 1'b1; if0.upd_valid = 1'b1; if0.upd_addr = 7'h09; if0.upd_data = 9'h0AA;
        #1;
        chk("rcfg_upd_ready", if0.upd_ready, 0);
        for (int i = 0; i < 11; i++) push(0, BOOT[i], 136);
        @(negedge clk);
        reconfig = 1'b0; if0.upd_valid = 1'b0;
        chk("rcfg_busy", busy0, 1); chk("rcfg_done_cleared", done0, 0); chk("rcfg_word_idx", widx0, 0);
        dcnt = 0;
        for (int i = 0; i < 2000 && busy0; i++) begin
            if (done0) dcnt++;
            @(negedge clk);
        end
        chk("rcfg_idle", busy0, 0); chk("rcfg_done_during_replay", dcnt, 0);
        chk("rcfg_done", done0, 1); chk("rcfg_nwords", nwords[0] - n0, 11);
        chk("rcfg_queue_empty", sbq.size(), 0);
        repeat (200) @(negedge clk);
        chk("rcfg_no_late_word", nwords[0] - n0, 11);

        // replay, then reset during bit 7 of word 3
        @(negedge clk);
        reconfig = 1'b1;
        for (int i = 0; i < 11; i++) push(0, BOOT[i], 136);
        @(negedge clk);
        reconfig = 1'b0;
        ab0 = aborted[0];
        for (int i = 0; i < 3000 && !(widx0 == 6'd3 && !cs0 && !sck0 && bits[0] == 7); i++) begin
            @(negedge clk);
            #1;
        end
        chk("abort_at_word", widx0, 3); chk("abort_at_bit", bits[0], 7);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_cs", cs0, 1); chk("abort_sck", sck0, 0);
        chk("abort_busy", busy0, 1); chk("abort_word_idx", widx0, 0);
        chk("abort_queue_left", sbq.size(), 8); chk("abort_partial", aborted[0] - ab0, 1);
        sbq.delete();
        repeat (2) @(negedge clk);

        // restart from entry 0 with a write held pending across the whole boot
        n0 = nwords[0];
        for (int i = 0; i < 11; i++) push(0, BOOT[i], 136);
        push(0, 16'h0812, 136);
        chk_first = 1'b1;
        reset = 1'b0;
        if0.upd_valid = 1'b1; if0.upd_addr = 7'h04; if0.upd_data = 9'h012;
        for (int i = 0; i < 4000 && !if0.upd_ready; i++) @(negedge clk);
        chk("held_upd_ready", if0.upd_ready, 1); chk("held_accept_after_done", done0, 1);
        @(negedge clk);
        if0.upd_valid = 1'b0; if0.upd_addr = 7'h7F; if0.upd_data = 9'h1FF;
        for (int i = 0; i < 400 && busy0; i++) @(negedge clk);
        chk("held_idle", busy0, 0); chk("held_nwords", nwords[0] - n0, 12);
        chk("held_word_idx", widx0, 10); chk("held_queue_empty", sbq.size(), 0);

        // CLK_DIV=1, GAP=1, single entry 0x1201: CS low 34 cycles
        n0 = nwords[1];
        push(1, 16'h1201, 34);
        @(negedge clk);
        rst1 = 1'b0;
        for (int i = 0; i < 200 && !done1; i++) @(negedge clk);
        chk("small_done", done1, 1); chk("small_busy", busy1, 0); chk("small_word_idx", widx1, 0);
        chk("small_nwords", nwords[1] - n0, 1); chk("small_queue_empty", sbq.size(), 0);

        // 8+8-bit words, CLK_DIV=2: CS low 68 cycles
        n0 = nwords[2];
        push(2, 16'h81C3, 68);
        push(2, 16'hA55A, 68);
        @(negedge clk);
        rst2 = 1'b0;
        for (int i = 0; i < 1000 && !done2; i++) @(negedge clk);
        chk("wide_done", done2, 1); chk("wide_busy", busy2, 0); chk("wide_word_idx", widx2, 1);
        chk("wide_nwords", nwords[2] - n0, 2); chk("wide_queue_empty", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
